issue_ctrl: RTL
===============

# issue_ctrl

Issue controller sitting between the instruction buffer and the dual-issue backend. Each cycle it inspects the two oldest buffered instructions and decides how many to pop (`o_size` 0/1/2). The decision applies dual-issue pairing rules, a one-cycle load-use interlock and a serialization FSM for special ops (CSR/barrier/ertn-class).

## Interface
Parameters: none.

- `clk`  in  1  clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  pipeline flush; same-cycle squash of issue, state cleared next edge.
- `ex_ready`  in  1  backend accepts an issue group this cycle.
- `pipe_empty`  in  1  no older instruction in flight past issue.
- `a_valid`, `b_valid`  in  1 each  buffer head slot valid (b implies a).
- `a_is_mem`, `b_is_mem`  in  1 each  load/store.
- `a_is_load`, `b_is_load`  in  1 each  load (subset of mem).
- `a_is_muldiv`, `b_is_muldiv`  in  1 each  multiply/divide.
- `a_is_br`, `b_is_br`  in  1 each  branch/jump.
- `a_is_spec_op`, `b_is_spec_op`  in  1 each  serializing op.
- `a_have_excp`, `b_have_excp`  in  1 each  fetch/decode exception attached.
- `a_dest`, `b_dest`  in  5 each  destination register (0 = none).
- `a_r1`, `a_r2`, `b_r1`, `b_r2`  in  5 each  source registers.
- `a_src2_is_imm`, `b_src2_is_imm`  in  1 each  src2 unused.
- `o_size`  out  2  instructions popped this cycle (0, 1, 2); combinational.
- `issue_a`, `issue_b`  out  1 each  slot issued (`issue_b` implies `issue_a`).
- `serial_busy`  out  1  FSM not in IDLE.

## Operation
- Registers: `state` (IDLE, DRAIN, ISSUE, WAIT), `ld_valid`, `ld_dest[4:0]`. Reset and flush values: IDLE, 0, 0.
- `o_size = issue_a + issue_b`. Issue is forced to 0 when `flush`, `!ex_ready` or `!a_valid`.
- Load-use hazard:
  - `hz(x) = ld_valid && ld_dest != 0 && (x_r1 == ld_dest || (!x_src2_is_imm && x_r2 == ld_dest))`.
  - hz(a) blocks all issue.
  - hz(b) blocks only b.
- Slot a in IDLE:
  - If `a_is_spec_op`: no issue; go to DRAIN.
  - Otherwise issue a unless hz(a).
- Slot b issues only if all of the following hold:
  - a issues, `b_valid`, and a is not br/spec/excp;
  - b is not spec/excp;
  - not both mem, not both muldiv;
  - no RAW on a: `a_dest != 0 && (b_r1 == a_dest || (!b_src2_is_imm && b_r2 == a_dest))`;
  - not hz(b).
- `a_have_excp` issues alone.
- Serialization FSM:
  - DRAIN: no issue; go to ISSUE when `pipe_empty`.
  - ISSUE: issue a alone when `ex_ready`, then go to WAIT; otherwise hold.
  - WAIT: no issue; go to IDLE when `pipe_empty`.
- `ld_valid`/`ld_dest` next value:
  - the dest of the issued load (slot a or b; at most one mem op per group) when that load issues and `ex_ready`;
  - otherwise `ld_valid` is 0.
- `flush` overrides everything: next state IDLE, `ld_valid` 0.

## Timing
- Zero-latency decision: `o_size`/`issue_*` are combinational from the current inputs and registered state. The buffer pops on the same edge.
- The load-use interlock lasts exactly one cycle after the load issues.
- Spec op minimum cost: 1 cycle DRAIN (if `pipe_empty` already high), 1 cycle ISSUE, then WAIT until `pipe_empty`.
- `reset` mid-operation: all registers return to reset values on the next edge. Outputs are 0 while `reset` is high (treated as `flush`).
- Simultaneous `flush` and an FSM transition: flush wins.

## Configuration
- `ISSUE_PERF_CNT_EN`:
  - Defined: adds output ports `perf_issue0`, `perf_issue1`, `perf_issue2`, `perf_ld_stall` (32-bit each, wrap on overflow, cleared by reset, not by flush).
    - The first three count cycles with `o_size` = 0/1/2 while `a_valid`.
    - `perf_ld_stall` counts cycles in which hz(a) or hz(b) reduces issue.
  - Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Independent add (a, dest 4) + sub (b, r1 5), `ex_ready=1` -> `o_size=2`.
- a writes r4, b reads r4 as r2 with `b_src2_is_imm=0` -> `o_size=1`; same with `b_src2_is_imm=1` -> `o_size=2`.
- Load to r7 issues; next cycle a reads r7 -> `o_size=0` for 1 cycle, then `o_size>=1`.
- Spec op at head with `pipe_empty=0` for 3 cycles -> DRAIN 3 cycles with `o_size=0`, then ISSUE `o_size=1`, WAIT until `pipe_empty`, then IDLE.
- `flush` asserted while in WAIT -> `o_size=0` that cycle, `serial_busy=0` next cycle.
- With `ISSUE_PERF_CNT_EN`: 10 cycles of dual issue -> `perf_issue2=10`; reset -> all counters 0.

Source files
------------

// File: rtl/issue_ctrl.sv
// Dual-issue controller: pairing rules, one-cycle load-use interlock and a
// serialization FSM for special ops. Optional perf counters via ISSUE_PERF_CNT_EN.
module issue_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       ex_ready,
    input  logic       pipe_empty,
    input  logic       a_valid,
    input  logic       b_valid,
    input  logic       a_is_mem,
    input  logic       b_is_mem,
    input  logic       a_is_load,
    input  logic       b_is_load,
    input  logic       a_is_muldiv,
    input  logic       b_is_muldiv,
    input  logic       a_is_br,
    input  logic       b_is_br,
    input  logic       a_is_spec_op,
    input  logic       b_is_spec_op,
    input  logic       a_have_excp,
    input  logic       b_have_excp,
    input  logic [4:0] a_dest,
    input  logic [4:0] b_dest,
    input  logic [4:0] a_r1,
    input  logic [4:0] a_r2,
    input  logic [4:0] b_r1,
    input  logic [4:0] b_r2,
    input  logic       a_src2_is_imm,
    input  logic       b_src2_is_imm,
    output logic [1:0] o_size,
    output logic       issue_a,
    output logic       issue_b,
    output logic       serial_busy
`ifdef ISSUE_PERF_CNT_EN
    ,
    output logic [31:0] perf_issue0,
    output logic [31:0] perf_issue1,
    output logic [31:0] perf_issue2,
    output logic [31:0] perf_ld_stall
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic       ld_valid_r;
    logic [4:0] ld_dest_r;
    logic       ld_valid_nxt_s;
    logic [4:0] ld_dest_nxt_s;
    logic       kill_s;
    logic       hz_a_s;
    logic       hz_b_s;
    logic       raw_s;
    logic       pair_ok_s;
    logic       stall_s;
    logic       unused_b_br_s;

    // Slot b may be a branch; pairing has no rule for it.
    assign unused_b_br_s = b_is_br;

    assign kill_s = reset | flush | ~ex_ready | ~a_valid;

    assign hz_a_s = ld_valid_r && (ld_dest_r != 5'd0) &&
                    ((a_r1 == ld_dest_r) || (!a_src2_is_imm && (a_r2 == ld_dest_r)));
    assign hz_b_s = ld_valid_r && (ld_dest_r != 5'd0) &&
                    ((b_r1 == ld_dest_r) || (!b_src2_is_imm && (b_r2 == ld_dest_r)));
    assign raw_s  = (a_dest != 5'd0) &&
                    ((b_r1 == a_dest) || (!b_src2_is_imm && (b_r2 == a_dest)));

    // Next-state and issue decision
    always_comb begin
        state_nxt_s = state_r;
        issue_a     = 1'b0;
        case (state_r)
            IDLE: begin
                if (a_valid && a_is_spec_op) begin
                    state_nxt_s = DRAIN;
                end else begin
                    issue_a = ~kill_s & ~hz_a_s;
                end
            end
            DRAIN: begin
                if (pipe_empty) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            ISSUE: begin
                if (!kill_s) begin
                    issue_a     = 1'b1;
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            WAIT: begin
                if (pipe_empty) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        if (reset || flush) begin
            state_nxt_s = IDLE;
        end else begin
            state_nxt_s = state_nxt_s;
        end
    end

    // Slot b pairs only with a normal slot-a issue out of IDLE
    assign pair_ok_s = issue_a && (state_r == IDLE) && b_valid &&
                       !a_is_br && !a_is_spec_op && !a_have_excp &&
                       !b_is_spec_op && !b_have_excp &&
                       !(a_is_mem && b_is_mem) && !(a_is_muldiv && b_is_muldiv) &&
                       !raw_s;
    assign issue_b     = pair_ok_s & ~hz_b_s;
    assign o_size      = {1'b0, issue_a} + {1'b0, issue_b};
    assign serial_busy = (state_r != IDLE);
    assign stall_s     = ((state_r == IDLE) && !kill_s && !a_is_spec_op && hz_a_s) ||
                         (pair_ok_s && hz_b_s);

    // Track the load issued this cycle for the next cycle's interlock
    always_comb begin
        ld_valid_nxt_s = 1'b0;
        ld_dest_nxt_s  = 5'd0;
        if (reset || flush) begin
            ld_valid_nxt_s = 1'b0;
            ld_dest_nxt_s  = 5'd0;
        end else if (issue_a && a_is_load) begin
            ld_valid_nxt_s = 1'b1;
            ld_dest_nxt_s  = a_dest;
        end else if (issue_b && b_is_load) begin
            ld_valid_nxt_s = 1'b1;
            ld_dest_nxt_s  = b_dest;
        end else begin
            ld_valid_nxt_s = 1'b0;
            ld_dest_nxt_s  = 5'd0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            ld_valid_r <= 1'b0;
            ld_dest_r  <= 5'd0;
        end else begin
            state_r    <= state_nxt_s;
            ld_valid_r <= ld_valid_nxt_s;
            ld_dest_r  <= ld_dest_nxt_s;
        end
    end

`ifdef ISSUE_PERF_CNT_EN
    // Performance counters: cleared by reset only, wrap on overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_issue0   <= 32'd0;
            perf_issue1   <= 32'd0;
            perf_issue2   <= 32'd0;
            perf_ld_stall <= 32'd0;
        end else begin
            if (a_valid) begin
                case (o_size)
                    2'd0:    perf_issue0 <= perf_issue0 + 32'd1;
                    2'd1:    perf_issue1 <= perf_issue1 + 32'd1;
                    2'd2:    perf_issue2 <= perf_issue2 + 32'd1;
                    default: perf_issue0 <= perf_issue0;
                endcase
            end else begin
                perf_issue0 <= perf_issue0;
            end
            if (stall_s) begin
                perf_ld_stall <= perf_ld_stall + 32'd1;
            end else begin
                perf_ld_stall <= perf_ld_stall;
            end
        end
    end
`else
    logic unused_stall_s;
    assign unused_stall_s = stall_s;
`endif

endmodule
